// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared bus definitions used by the arbiter and its round-robin helper:
//   bus widths, owner encoding, active-low enable / direction constants,
//   default watchdog limit, and the per-master request/response bundles.
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    localparam int WORD_ADDR_W   = 30;
    localparam int WORD_DATA_W   = 32;
    localparam int BUS_MASTER_CH = 4;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [WORD_DATA_W-1:0] word_data_t;

    // Owner index (BUS_OWNER_BUS)
    typedef logic [1:0] bus_owner_t;

    localparam bus_owner_t BUS_OWNER_M0 = 2'd0;
    localparam bus_owner_t BUS_OWNER_M1 = 2'd1;
    localparam bus_owner_t BUS_OWNER_M2 = 2'd2;
    localparam bus_owner_t BUS_OWNER_M3 = 2'd3;

    localparam logic [7:0] BUS_TIMEOUT_DEFAULT = 8'd255;

    // Active-low enable levels and bus direction encoding
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    // Watchdog view: COUNT while below the limit, FORCE when the limit is hit.
    // Purely a decode of the wait counter; no state of its own.
    typedef enum logic {
        TO_COUNT = 1'b0,
        TO_FORCE = 1'b1
    } to_state_e;

    // Master -> shared bus request bundle
    typedef struct packed {
        word_addr_t addr;
        logic       as_n;
        logic       rw;
        word_data_t wr_data;
    } bus_req_t;

    // Shared bus -> master response bundle
    typedef struct packed {
        word_data_t rd_data;
        logic       rdy_n;
    } bus_rsp_t;

    // Active-low one-cold grant vector for a given owner.
    function automatic logic [BUS_MASTER_CH-1:0] owner_grant_n(input bus_owner_t owner);
        logic [BUS_MASTER_CH-1:0] onehot;
        onehot = BUS_MASTER_CH'(1) << owner;
        return ~onehot;
    endfunction

endpackage

// File: rtl/bus_rr_next.sv
// -----------------------------------------------------------------------------
// bus_rr_next
//   Combinational round-robin next-owner selection.
//   The current owner keeps the bus while its request is asserted. Otherwise
//   the search starts at owner+1 and wraps; the first requester wins. With no
//   requester the current owner is kept (parking).
//
//   owner      : in  current owner index
//   req_n      : in  active-low requests, one bit per master
//   next_owner : out owner for the next cycle
// -----------------------------------------------------------------------------
module bus_rr_next
    import bus_arbiter_pkg::*;
(
    input  bus_owner_t               owner,
    input  logic [BUS_MASTER_CH-1:0] req_n,
    output bus_owner_t               next_owner
);

    logic [BUS_MASTER_CH-1:0]   req;
    logic [2*BUS_MASTER_CH-1:0] req2x;
    logic [2:0]                 shift;
    logic [BUS_MASTER_CH-2:0]   cand;

    always_comb begin
        req   = ~req_n;
        // Doubling the vector lets a plain slice rotate the requests so that
        // cand[0] is owner+1, cand[1] is owner+2, ...
        req2x = {req, req};
        shift = {1'b0, owner} + 3'd1;
        cand  = req2x[shift +: (BUS_MASTER_CH-1)];

        next_owner = owner;
        if (!req[owner]) begin
            // Walk from the farthest candidate down so the nearest one wins.
            for (int k = BUS_MASTER_CH-2; k >= 0; k--) begin
                if (cand[k]) begin
                    next_owner = owner + bus_owner_t'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Four-master shared-bus arbiter and master multiplexer.
//   Round-robin ownership with registered active-low grants, a combinational
//   mux of the owner's address/control onto the shared bus, a combinational
//   return path of slave data/ready to the owner only, and a watchdog that
//   force-completes accesses the slave never acknowledges.
//
//   clk, reset_          : clock, asynchronous active-low reset
//   MnBusReq_ / Grnt_    : per-master request in / registered grant out
//   MnBusAddr/As_/RW/WrData : per-master access inputs
//   MnBusRdData / Rdy_   : per-master return path
//   BusAddr/As_/RW/WrData: shared bus, copied from the owner
//   SBusRdData / SBusRdy_: slave response
//   BusTimeout           : high in the cycle an access is force-completed
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_,

    input  logic        M0BusReq_,
    output logic        M0BusGrnt_,
    input  logic [29:0] M0BusAddr,
    input  logic        M0BusAs_,
    input  logic        M0BusRW,
    input  logic [31:0] M0BusWrData,
    output logic [31:0] M0BusRdData,
    output logic        M0BusRdy_,

    input  logic        M1BusReq_,
    output logic        M1BusGrnt_,
    input  logic [29:0] M1BusAddr,
    input  logic        M1BusAs_,
    input  logic        M1BusRW,
    input  logic [31:0] M1BusWrData,
    output logic [31:0] M1BusRdData,
    output logic        M1BusRdy_,

    input  logic        M2BusReq_,
    output logic        M2BusGrnt_,
    input  logic [29:0] M2BusAddr,
    input  logic        M2BusAs_,
    input  logic        M2BusRW,
    input  logic [31:0] M2BusWrData,
    output logic [31:0] M2BusRdData,
    output logic        M2BusRdy_,

    input  logic        M3BusReq_,
    output logic        M3BusGrnt_,
    input  logic [29:0] M3BusAddr,
    input  logic        M3BusAs_,
    input  logic        M3BusRW,
    input  logic [31:0] M3BusWrData,
    output logic [31:0] M3BusRdData,
    output logic        M3BusRdy_,

    output logic [29:0] BusAddr,
    output logic        BusAs_,
    output logic        BusRW,
    output logic [31:0] BusWrData,

    input  logic [31:0] SBusRdData,
    input  logic        SBusRdy_,
    output logic        BusTimeout
);

    // ------------------------------------------------------------------
    // Pack per-master ports into arrays
    // ------------------------------------------------------------------
    logic     [BUS_MASTER_CH-1:0] req_n;
    bus_req_t [BUS_MASTER_CH-1:0] mreq;
    bus_rsp_t [BUS_MASTER_CH-1:0] mrsp;

    assign req_n   = {M3BusReq_, M2BusReq_, M1BusReq_, M0BusReq_};
    assign mreq[0] = {M0BusAddr, M0BusAs_, M0BusRW, M0BusWrData};
    assign mreq[1] = {M1BusAddr, M1BusAs_, M1BusRW, M1BusWrData};
    assign mreq[2] = {M2BusAddr, M2BusAs_, M2BusRW, M2BusWrData};
    assign mreq[3] = {M3BusAddr, M3BusAs_, M3BusRW, M3BusWrData};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    bus_owner_t               owner_q, owner_d, rr_owner;
    logic [7:0]               wait_cnt_q, wait_cnt_d;
    logic [BUS_MASTER_CH-1:0] grnt_q, grnt_d;

    bus_req_t  cur;
    logic      waiting;
    logic      force_end;
    to_state_e to_state;

    bus_rr_next u_rr_next (
        .owner      (owner_q),
        .req_n      (req_n),
        .next_owner (rr_owner)
    );

    always_comb begin
        cur       = mreq[owner_q];
        to_state  = (wait_cnt_q == TIMEOUT) ? TO_FORCE : TO_COUNT;
        // A slave ready in the limit cycle means the access is not waiting,
        // so real data wins over the forced termination.
        waiting   = (cur.as_n == ENABLE_) && (SBusRdy_ == DISABLE_);
        force_end = waiting && (to_state == TO_FORCE);

        owner_d = rr_owner;

        // Counter only survives a cycle in which the same owner keeps waiting
        // and no forced termination happened.
        if ((owner_d != owner_q) || !waiting || force_end) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        // Grants are decoded from the next owner so the flop holds the
        // final active-low value and no decode sits after it.
        grnt_d = owner_grant_n(owner_d);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            owner_q    <= BUS_OWNER_M0;
            wait_cnt_q <= '0;
            grnt_q     <= owner_grant_n(BUS_OWNER_M0);
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            grnt_q     <= grnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Shared-bus mux: straight copy of the owner's request
    // ------------------------------------------------------------------
    assign BusAddr   = cur.addr;
    assign BusAs_    = cur.as_n;
    assign BusRW     = cur.rw;
    assign BusWrData = cur.wr_data;

    // Timeout pulse coincides with the forced ready, so it is decoded in the
    // same cycle rather than delayed through a flop.
    assign BusTimeout = force_end;

    // ------------------------------------------------------------------
    // Return path: only the owner sees the slave; others read idle values
    // ------------------------------------------------------------------
    for (genvar n = 0; n < BUS_MASTER_CH; n++) begin : g_rsp
        logic own;
        assign own = (owner_q == bus_owner_t'(n));
        assign mrsp[n].rd_data = (own && !force_end) ? SBusRdData : '0;
        // force_end implies SBusRdy_ is high, so masking pulls ready low.
        assign mrsp[n].rdy_n   = own ? (SBusRdy_ & ~force_end) : DISABLE_;
    end

    assign M0BusGrnt_  = grnt_q[0];
    assign M1BusGrnt_  = grnt_q[1];
    assign M2BusGrnt_  = grnt_q[2];
    assign M3BusGrnt_  = grnt_q[3];

    assign M0BusRdData = mrsp[0].rd_data;
    assign M1BusRdData = mrsp[1].rd_data;
    assign M2BusRdData = mrsp[2].rd_data;
    assign M3BusRdData = mrsp[3].rd_data;

    assign M0BusRdy_   = mrsp[0].rdy_n;
    assign M1BusRdy_   = mrsp[1].rdy_n;
    assign M2BusRdy_   = mrsp[2].rdy_n;
    assign M3BusRdy_   = mrsp[3].rdy_n;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed scenarios followed by random traffic. Each driven cycle pushes
//   the reference model's expected outputs into a queue; a negedge monitor
//   pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam logic [7:0] TO = 8'd4;

    logic        clk;
    logic        reset_;
    logic [3:0]  req_n;
    logic [3:0]  as_n;
    logic [3:0]  rw;
    logic [29:0] addr  [4];
    logic [31:0] wdata [4];
    logic        srdy;
    logic [31:0] sdata;

    wire  [3:0]       grnt;
    wire  [3:0]       rdy;
    wire  [3:0][31:0] rdata;
    wire  [29:0]      bus_addr;
    wire              bus_as_n;
    wire              bus_rw;
    wire  [31:0]      bus_wdata;
    wire              bus_to;

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_(reset_),
        .M0BusReq_(req_n[0]), .M0BusGrnt_(grnt[0]), .M0BusAddr(addr[0]), .M0BusAs_(as_n[0]),
        .M0BusRW(rw[0]), .M0BusWrData(wdata[0]), .M0BusRdData(rdata[0]), .M0BusRdy_(rdy[0]),
        .M1BusReq_(req_n[1]), .M1BusGrnt_(grnt[1]), .M1BusAddr(addr[1]), .M1BusAs_(as_n[1]),
        .M1BusRW(rw[1]), .M1BusWrData(wdata[1]), .M1BusRdData(rdata[1]), .M1BusRdy_(rdy[1]),
        .M2BusReq_(req_n[2]), .M2BusGrnt_(grnt[2]), .M2BusAddr(addr[2]), .M2BusAs_(as_n[2]),
        .M2BusRW(rw[2]), .M2BusWrData(wdata[2]), .M2BusRdData(rdata[2]), .M2BusRdy_(rdy[2]),
        .M3BusReq_(req_n[3]), .M3BusGrnt_(grnt[3]), .M3BusAddr(addr[3]), .M3BusAs_(as_n[3]),
        .M3BusRW(rw[3]), .M3BusWrData(wdata[3]), .M3BusRdData(rdata[3]), .M3BusRdy_(rdy[3]),
        .BusAddr(bus_addr), .BusAs_(bus_as_n), .BusRW(bus_rw), .BusWrData(bus_wdata),
        .SBusRdData(sdata), .SBusRdy_(srdy), .BusTimeout(bus_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       grnt;
        logic [63:0]      bus;
        logic [3:0][31:0] rdata;
        logic [3:0]       rdy;
        logic             to;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   to_seen = 0;
    bit   rec_en = 1'b0;
    int   last_idx = -1;
    int   obs_order[$];

    // Reference model state: owner index and waiting-cycle count
    int   m_owner = 0;
    int   m_wc    = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    endtask

    // Compute expected outputs for the current inputs, queue them, advance
    // the model, then move to 2 time units after the next rising edge.
    task automatic step();
        exp_t e;
        int   o;
        int   nx;
        bit   waiting;
        bit   fire;
        o       = m_owner;
        waiting = (as_n[o] == 1'b0) && (srdy == 1'b1);
        fire    = waiting && (m_wc == int'(TO));
        e.grnt    = 4'hF;
        e.grnt[o] = 1'b0;
        e.bus     = {addr[o], as_n[o], rw[o], wdata[o]};
        for (int n = 0; n < 4; n++) begin
            e.rdata[n] = (n == o && !fire) ? sdata : 32'h0;
            e.rdy[n]   = (n != o) ? 1'b1 : (fire ? 1'b0 : srdy);
        end
        e.to = fire;
        exp_q.push_back(e);

        nx = o;
        if (req_n[o]) begin
            for (int k = 1; k < 4; k++) begin
                if (!req_n[(o + k) % 4]) begin
                    nx = (o + k) % 4;
                    break;
                end
            end
        end
        m_wc    = (nx != o || !waiting || fire) ? 0 : m_wc + 1;
        m_owner = nx;
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        exp_t e;
        int   idx;
        if (bus_to === 1'b1) to_seen++;
        idx = -1;
        for (int n = 0; n < 4; n++) if (grnt[n] == 1'b0) idx = n;
        if (rec_en && idx != last_idx) begin
            obs_order.push_back(idx);
            last_idx = idx;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant", 128'(grnt), 128'(e.grnt));
            chk("grant_onehot", 128'($countones(~grnt)), 128'(1));
            chk("bus_mux", 128'({bus_addr, bus_as_n, bus_rw, bus_wdata}), 128'(e.bus));
            chk("rd_data", rdata, e.rdata);
            chk("rdy", 128'(rdy), 128'(e.rdy));
            chk("timeout", 128'(bus_to), 128'(e.to));
        end
    end

    initial begin
        int left [4];
        bit rel  [4];
        int o;
        int t0;
        int want_order [5];

        reset_ = 1'b0;
        req_n  = 4'hF;
        as_n   = 4'hF;
        rw     = 4'hF;
        srdy   = 1'b1;
        sdata  = 32'h5A5A_0001;
        for (int n = 0; n < 4; n++) begin
            addr[n]  = 30'h100 * 30'(n + 1);
            wdata[n] = 32'h1111_0000 * 32'(n + 1);
        end

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #2;
        chk("reset_grant", 128'(grnt), 128'(4'b1110));
        chk("reset_timeout", 128'(bus_to), 128'(0));
        chk("reset_bus", 128'({bus_addr, bus_as_n, bus_rw, bus_wdata}),
            128'({addr[0], as_n[0], rw[0], wdata[0]}));
        chk("reset_rdy", 128'(rdy), 128'(4'b1111));
        reset_  = 1'b1;
        m_owner = 0;
        m_wc    = 0;

        // ---------------- contention: order 0,1,2,3,0 ----------------
        left = '{2, 1, 1, 1};
        rel  = '{0, 0, 0, 0};
        rec_en = 1'b1;
        repeat (12) begin
            for (int n = 0; n < 4; n++) begin
                req_n[n] = (left[n] > 0 && !rel[n]) ? 1'b0 : 1'b1;
                rel[n]   = 1'b0;
            end
            as_n  = 4'hF;
            srdy  = 1'b1;
            sdata = $urandom;
            o = m_owner;
            if (req_n[o] == 1'b0) begin
                as_n[o] = 1'b0;
                srdy    = 1'b0;
                left[o] = left[o] - 1;
                rel[o]  = 1'b1;
            end
            step();
        end
        rec_en = 1'b0;
        want_order = '{0, 1, 2, 3, 0};
        chk("order_len", 128'(obs_order.size()), 128'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < obs_order.size()) chk("order", 128'(obs_order[i]), 128'(want_order[i]));
        end

        // ---------------- single request from M1 ----------------
        req_n = 4'hF;
        as_n  = 4'hF;
        addr[1] = 30'h0000_1234;
        repeat (4) step();
        req_n = 4'b1101;
        repeat (3) step();

        // ---------------- hold and isolation ----------------
        req_n = 4'b1011;
        step();
        req_n = 4'b0011;
        repeat (20) begin
            as_n  = {1'b0, 1'($urandom), 1'($urandom), 1'($urandom)};
            srdy  = 1'($urandom);
            sdata = $urandom;
            step();
        end

        // ---------------- timeout with slave never ready ----------------
        req_n = 4'b1110;
        as_n  = 4'hF;
        srdy  = 1'b1;
        step();
        t0 = to_seen;
        repeat (5) begin
            as_n[0] = 1'b0;
            srdy    = 1'b1;
            sdata   = $urandom | 32'h1;
            step();
        end
        chk("timeout_pulses", 128'(to_seen - t0), 128'(1));
        as_n = 4'hF;
        step();

        // ---------------- slave ready exactly at the limit ----------------
        t0 = to_seen;
        repeat (4) begin
            as_n[0] = 1'b0;
            srdy    = 1'b1;
            step();
        end
        srdy  = 1'b0;
        sdata = 32'hCAFE_F00D;
        step();
        chk("limit_no_timeout", 128'(to_seen - t0), 128'(0));

        // ---------------- reset mid-access ----------------
        req_n = 4'b0111;
        as_n  = 4'hF;
        srdy  = 1'b1;
        step();
        repeat (3) begin
            as_n[3] = 1'b0;
            step();
        end
        chk("midacc_grant", 128'(grnt), 128'(4'b0111));
        chk("midacc_waitcnt", 128'(dut.wait_cnt_q), 128'(3));
        reset_ = 1'b0;
        #1;
        chk("async_grant", 128'(grnt), 128'(4'b1110));
        chk("async_waitcnt", 128'(dut.wait_cnt_q), 128'(0));
        chk("async_timeout", 128'(bus_to), 128'(0));
        chk("async_bus", 128'({bus_addr, bus_as_n, bus_rw, bus_wdata}),
            128'({addr[0], as_n[0], rw[0], wdata[0]}));
        reset_  = 1'b1;
        m_owner = 0;
        m_wc    = 0;
        req_n   = 4'hF;
        as_n    = 4'hF;
        step();

        // ---------------- random traffic ----------------
        repeat (400) begin
            for (int n = 0; n < 4; n++) begin
                req_n[n] = 1'($urandom);
                as_n[n]  = ($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1;
                rw[n]    = 1'($urandom);
                addr[n]  = 30'($urandom);
                wdata[n] = $urandom;
            end
            // Bias the current owner toward keeping the bus so stalls can
            // run long enough to reach the watchdog limit.
            req_n[m_owner] = ($urandom_range(0, 9) < 8) ? 1'b0 : 1'b1;
            srdy  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            sdata = $urandom;
            step();
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
